// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the interrupt controller slice:
//     - default number of interrupt sources and default handler base address
//     - FSM state encoding (also exported on the controller's debug port)
//     - lowest_index(): priority helper, lowest set bit wins
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int          DEFAULT_NUM_SOURCES = 8;
    localparam logic [15:0] DEFAULT_VECTOR_BASE = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_COOLDOWN = 2'd2
    } irq_state_e;

    // Returns the index of the lowest set bit of req (0 if req is zero).
    // Scanning from the top down lets the lowest index overwrite the result last.
    function automatic logic [3:0] lowest_index(input logic [15:0] req);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
//   One-bit synchronizer for an asynchronous level interrupt source, followed
//   by a history flop for rising-edge detection.
//
//   Ports:
//     clock  in   single clock, all flops on posedge
//     reset  in   asynchronous active-low reset, clears all three flops
//     din    in   asynchronous level input
//     rise   out  one-cycle pulse: synchronized input high, history low
//
//   The history flop resets to 0, so a source that is already high when reset
//   is released is reported as a fresh edge.
// ---------------------------------------------------------------------------
module irq_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Vectored, fixed-priority interrupt controller.  Each source is
//   synchronized and edge-detected; edges latch into pending bits (merged, not
//   counted).  A three-state FSM (IDLE -> REQUEST -> COOLDOWN) picks the
//   lowest-index pending and enabled source, raises irq with its handler
//   address, waits for the acknowledge and then holds irq low for one cycle.
//
//   Parameters:
//     NUM_SOURCES  number of interrupt sources (2..16)
//     VECTOR_BASE  handler address of source 0; source i uses VECTOR_BASE + i
//
//   Ports:
//     clock         in   single clock, all state on posedge
//     reset         in   asynchronous active-low reset
//     irq_src       in   asynchronous level sources, rising edge = request
//     mask_write    in   one-cycle strobe, loads mask from mask_data
//     mask_data     in   new enable mask (1 = enabled)
//     reset_irq     in   acknowledge, honoured only in REQUEST
//     irq           out  registered interrupt request (1 iff in REQUEST)
//     irq_vector    out  handler address of the in-service source
//     pending       out  registered pending bits
//     active_index  out  index of the in-service source
//     state_dbg     out  current FSM state (irq_state_e encoding)
// ---------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SOURCES = DEFAULT_NUM_SOURCES,
    parameter logic [15:0] VECTOR_BASE = DEFAULT_VECTOR_BASE
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   mask_write,
    input  logic [NUM_SOURCES-1:0] mask_data,
    input  logic                   reset_irq,
    output logic                   irq,
    output logic [15:0]            irq_vector,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [3:0]             active_index,
    output logic [1:0]             state_dbg
);

    // -----------------------------------------------------------------------
    // Per-source synchronizer and edge detector
    // -----------------------------------------------------------------------
    logic [NUM_SOURCES-1:0] rise;

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
        irq_sync_edge u_sync_edge (
            .clock (clock),
            .reset (reset),
            .din   (irq_src[i]),
            .rise  (rise[i])
        );
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    irq_state_e             state_q;
    irq_state_e             state_n;
    logic                   irq_q;
    logic [NUM_SOURCES-1:0] mask_q;
    logic [NUM_SOURCES-1:0] pending_q;
    logic [NUM_SOURCES-1:0] pending_n;
    logic [3:0]             active_q;
    logic [15:0]            vector_q;

    // -----------------------------------------------------------------------
    // Priority selection: only the registered mask is used, so a mask write in
    // the same cycle as an IDLE selection takes effect one cycle later.
    // -----------------------------------------------------------------------
    logic [15:0] req16;
    logic [3:0]  sel;
    logic        any_req;

    always_comb begin
        req16                    = '0;
        req16[NUM_SOURCES-1:0]   = pending_q & mask_q;
        sel                      = lowest_index(req16);
        any_req                  = |req16;
    end

    // -----------------------------------------------------------------------
    // FSM next state.  reset_irq only matters in REQUEST; the mask is not
    // consulted there, so a mask change cannot withdraw a latched request.
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_n = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (reset_irq) begin
                    state_n = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending bits: acknowledge clears the in-service bit first, then new
    // edges are OR-ed in, so an edge coincident with its own acknowledge wins.
    // -----------------------------------------------------------------------
    always_comb begin
        pending_n = pending_q;
        if (state_q == ST_REQUEST && reset_irq) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (active_q == 4'(i)) begin
                    pending_n[i] = 1'b0;
                end
            end
        end
        pending_n = pending_n | rise;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            mask_q    <= '0;
            pending_q <= '0;
            active_q  <= 4'd0;
            vector_q  <= VECTOR_BASE;
        end else begin
            state_q   <= state_n;
            // irq is its own flop so the output never sees state decode glitches
            irq_q     <= (state_n == ST_REQUEST);
            pending_q <= pending_n;
            if (mask_write) begin
                mask_q <= mask_data;
            end
            // Vector and index only change on selection, so they are stable
            // for the whole time irq is high.  16-bit add wraps by design.
            if (state_q == ST_IDLE && any_req) begin
                active_q <= sel;
                vector_q <= VECTOR_BASE + {12'd0, sel};
            end
        end
    end

    assign irq          = irq_q;
    assign irq_vector   = vector_q;
    assign pending      = pending_q;
    assign active_index = active_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
//   Directed bench for irq_controller (NUM_SOURCES = 8, VECTOR_BASE = FFF0).
//   Inputs change 1 ns after a rising edge; outputs are checked 1 ns after a
//   rising edge, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_irq_controller;

    logic        clock;
    logic        reset;
    logic [7:0]  irq_src;
    logic        mask_write;
    logic [7:0]  mask_data;
    logic        reset_irq;
    logic        irq;
    logic [15:0] irq_vector;
    logic [7:0]  pending;
    logic [3:0]  active_index;
    logic [1:0]  state_dbg;

    int checks;
    int errors;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQUEST  = 2'd1;
    localparam logic [1:0] S_COOLDOWN = 2'd2;

    irq_controller #(
        .NUM_SOURCES (8),
        .VECTOR_BASE (16'hFFF0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .irq_src      (irq_src),
        .mask_write   (mask_write),
        .mask_data    (mask_data),
        .reset_irq    (reset_irq),
        .irq          (irq),
        .irq_vector   (irq_vector),
        .pending      (pending),
        .active_index (active_index),
        .state_dbg    (state_dbg)
    );

    // clock / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    // driver helpers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_data  = m;
        mask_write = 1'b1;
        tick();
        mask_write = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        irq_src    = 8'h00;
        mask_write = 1'b0;
        mask_data  = 8'h00;
        reset_irq  = 1'b0;

        // ---------------- reset state ----------------
        ticks(3);
        chk("rst_irq",     32'(irq),          32'h0);
        chk("rst_pending", 32'(pending),      32'h0);
        chk("rst_active",  32'(active_index), 32'h0);
        chk("rst_vector",  32'(irq_vector),   32'hFFF0);
        chk("rst_state",   32'(state_dbg),    32'(S_IDLE));
        reset = 1'b1;
        ticks(2);

        // ---------------- single source, latency 3 ----------------
        write_mask(8'h04);
        irq_src[2] = 1'b1;
        tick();                                   // k
        chk("lat_k0_irq", 32'(irq), 32'h0);
        tick();                                   // k+1
        chk("lat_k1_irq", 32'(irq), 32'h0);
        tick();                                   // k+2
        chk("lat_k2_pending", 32'(pending), 32'h04);
        chk("lat_k2_irq",     32'(irq),     32'h0);
        tick();                                   // k+3
        chk("lat_k3_irq",    32'(irq),          32'h1);
        chk("lat_k3_vector", 32'(irq_vector),   32'hFFF2);
        chk("lat_k3_active", 32'(active_index), 32'h2);
        irq_src[2] = 1'b0;
        reset_irq  = 1'b1;
        tick();
        chk("ack2_irq",     32'(irq),       32'h0);
        chk("ack2_pending", 32'(pending),   32'h00);
        chk("ack2_state",   32'(state_dbg), 32'(S_COOLDOWN));
        reset_irq = 1'b0;
        tick();
        chk("ack2_idle", 32'(state_dbg), 32'(S_IDLE));
        ticks(3);

        // ---------------- priority: sources 1 and 5 together ----------------
        write_mask(8'hFF);
        irq_src = 8'h22;
        ticks(3);
        chk("pri_pending", 32'(pending), 32'h22);
        irq_src = 8'h00;
        tick();
        chk("pri1_irq",    32'(irq),          32'h1);
        chk("pri1_vector", 32'(irq_vector),   32'hFFF1);
        chk("pri1_active", 32'(active_index), 32'h1);
        reset_irq = 1'b1;
        tick();
        chk("pri1_ack_irq",     32'(irq),     32'h0);
        chk("pri1_ack_pending", 32'(pending), 32'h20);
        reset_irq = 1'b0;
        tick();
        chk("pri_gap_irq", 32'(irq), 32'h0);
        tick();
        chk("pri5_irq",    32'(irq),          32'h1);
        chk("pri5_vector", 32'(irq_vector),   32'hFFF5);
        chk("pri5_active", 32'(active_index), 32'h5);
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
        tick();
        chk("pri_done_pending", 32'(pending), 32'h00);
        ticks(2);

        // ---------------- masked source, then mask write ----------------
        write_mask(8'h00);
        irq_src[3] = 1'b1;
        ticks(3);
        chk("msk_pending", 32'(pending), 32'h08);
        chk("msk_irq",     32'(irq),     32'h0);
        // acknowledge in IDLE must be ignored
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
        chk("idle_ack_pending", 32'(pending),   32'h08);
        chk("idle_ack_state",   32'(state_dbg), 32'(S_IDLE));
        tick();
        mask_data  = 8'h08;
        mask_write = 1'b1;
        tick();                                   // write posedge: old mask used
        mask_write = 1'b0;
        chk("msk_w0_irq", 32'(irq), 32'h0);
        tick();
        chk("msk_w1_irq",    32'(irq),        32'h1);
        chk("msk_w1_vector", 32'(irq_vector), 32'hFFF3);
        irq_src[3] = 1'b0;
        reset_irq  = 1'b1;
        tick();
        reset_irq = 1'b0;
        tick();
        ticks(2);

        // ---------------- mask cleared during REQUEST ----------------
        write_mask(8'h01);
        irq_src[0] = 1'b1;
        ticks(4);
        chk("m0_irq",    32'(irq),        32'h1);
        chk("m0_vector", 32'(irq_vector), 32'hFFF0);
        irq_src[0] = 1'b0;
        write_mask(8'h00);
        chk("m0_keep_irq", 32'(irq), 32'h1);
        tick();
        chk("m0_keep2_irq", 32'(irq), 32'h1);
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
        chk("m0_ack_irq",     32'(irq),     32'h0);
        chk("m0_ack_pending", 32'(pending), 32'h00);
        ticks(3);

        // ---------------- edge coincident with acknowledge ----------------
        write_mask(8'h10);
        irq_src[4] = 1'b1;
        ticks(4);
        chk("co_irq",    32'(irq),          32'h1);
        chk("co_active", 32'(active_index), 32'h4);
        irq_src[4] = 1'b0;
        ticks(3);                                  // flush synchronizer + history
        chk("co_hold_irq", 32'(irq), 32'h1);
        irq_src[4] = 1'b1;
        tick();                                    // q: sync1
        tick();                                    // q+1: sync2, edge now visible
        reset_irq = 1'b1;
        tick();                                    // q+2: ack and edge together
        reset_irq = 1'b0;
        chk("co_ack_irq",     32'(irq),       32'h0);
        chk("co_ack_pending", 32'(pending),   32'h10);
        chk("co_ack_state",   32'(state_dbg), 32'(S_COOLDOWN));
        // acknowledge held into COOLDOWN must not disturb anything
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
        chk("co_idle_state", 32'(state_dbg), 32'(S_IDLE));
        tick();
        chk("co_re_irq",    32'(irq),        32'h1);
        chk("co_re_vector", 32'(irq_vector), 32'hFFF4);
        irq_src[4] = 1'b0;
        reset_irq  = 1'b1;
        tick();
        reset_irq = 1'b0;
        ticks(3);

        // ---------------- reset during REQUEST ----------------
        write_mask(8'h01);
        irq_src = 8'h81;
        ticks(4);
        chk("rq_irq",     32'(irq),     32'h1);
        chk("rq_pending", 32'(pending), 32'h81);
        #2;
        reset = 1'b0;
        #1;                                        // still before next posedge
        chk("rq_async_irq",     32'(irq),       32'h0);
        chk("rq_async_pending", 32'(pending),   32'h00);
        chk("rq_async_state",   32'(state_dbg), 32'(S_IDLE));
        ticks(2);
        reset = 1'b1;                              // sources still held high
        tick();
        chk("rel_p1_pending", 32'(pending), 32'h00);
        tick();
        tick();
        chk("rel_p3_pending", 32'(pending), 32'h81);
        tick();
        chk("rel_mask_off_irq", 32'(irq), 32'h0);
        irq_src = 8'h00;
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
